fp_soc_key_debounce: RTL

- Upstream conditioning stage for the SoC key PIO.
- Takes raw, bouncing, asynchronous push-button inputs (active-low board keys) and synchronizes them to clk. Debounces each key independently with a per-key stability counter.
- Drives the clean level straight into the key PIO's in_port. Also emits one-cycle press/release pulses for fabric logic.

---
 rtl/fp_soc_key_debounce.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fp_soc_key_debounce.sv
// fp_soc_key_debounce
//
// Conditions raw, bouncing, active-low board push-buttons for the SoC key PIO.
// Each key is brought into the clk domain through a two-flop synchronizer.
// It is then debounced by its own two-state FSM with a stability counter.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from the current clean level. Any sample
// that matches the clean level again restarts the window from zero.
//
// Optional feature (compile-time macro KEY_DEBOUNCE_LATCH_EN):
//   Adds a sticky per-key press latch with a software clear. Software can then
//   catch presses that are shorter than its polling period. When the macro is
//   undefined, the latch ports and flops do not exist.
//
// Parameters:
//   NUM_KEYS        number of independent key channels (>= 1)
//   DEBOUNCE_CYCLES consecutive stable cycles to accept a change (>= 2)
//   CNT_W           counter width; 2**CNT_W must exceed DEBOUNCE_CYCLES
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset (synchronous release assumed)
//   key_raw_i        raw asynchronous keys, active-low (0 = pressed)
//   key_out_o        debounced level, same polarity as key_raw_i (to PIO in_port)
//   press_pulse_o    one-cycle pulse when a key_out_o bit goes 1->0
//   release_pulse_o  one-cycle pulse when a key_out_o bit goes 0->1
//   latch_clr_i      (macro only) per-key clear for key_latched_o
//   key_latched_o    (macro only) sticky per-key press indication

module fp_soc_key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  output logic [NUM_KEYS-1:0] key_out_o,
  output logic [NUM_KEYS-1:0] press_pulse_o,
  output logic [NUM_KEYS-1:0] release_pulse_o
`ifdef KEY_DEBOUNCE_LATCH_EN
  ,
  input  logic [NUM_KEYS-1:0] latch_clr_i,
  output logic [NUM_KEYS-1:0] key_latched_o
`endif
);

  // Count value on which the change is accepted. The first differing sample
  // loads 1, so acceptance happens on the DEBOUNCE_CYCLES-th differing sample.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    StStable,
    StChanging
  } key_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. The reset value is all ones (released), so a key
  // that is held through reset is re-qualified from scratch after release.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce FSM with registered level and pulse outputs.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= StStable;
        cnt_q     <= '0;
        level_q   <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        // Pulses are high only for the cycle that follows an accepted change.
        press_q   <= 1'b0;
        release_q <= 1'b0;
        unique case (state_q)
          StStable: begin
            if (sync2_q[k] != level_q) begin
              state_q <= StChanging;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          StChanging: begin
            if (sync2_q[k] == level_q) begin
              // Bounce back to the clean level: restart the whole window.
              state_q <= StStable;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q   <= StStable;
              cnt_q     <= '0;
              level_q   <= sync2_q[k];
              press_q   <= ~sync2_q[k];
              release_q <= sync2_q[k];
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StStable;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign key_out_o[k]       = level_q;
    assign press_pulse_o[k]   = press_q;
    assign release_pulse_o[k] = release_q;
  end

`ifdef KEY_DEBOUNCE_LATCH_EN
  // ---------------------------------------------------------------------------
  // Sticky press latch. A press that coincides with a clear wins, so a press
  // can never be lost to a clear that races with it.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] latched_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched_q <= '0;
    end else begin
      latched_q <= press_pulse_o | (latched_q & ~latch_clr_i);
    end
  end

  assign key_latched_o = latched_q;
`endif

endmodule
